// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the data-memory path.
//   LONG_*       access-size encodings carried on the *_long ports
//   dbg_state_e  state encoding of the debug dump sequencer
//   mem_req_t    one complete request onto the data-memory port
//   DMEM_DEPTH   number of 32-bit words in data memory
package mips_pkg;

  localparam int DMEM_DEPTH = 32;

  localparam logic [1:0] LONG_BYTE = 2'b00;
  localparam logic [1:0] LONG_HALF = 2'b01;
  localparam logic [1:0] LONG_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } dbg_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwrite;
    logic        memread;
    logic [1:0]  long_sz;
    logic        sign;
  } mem_req_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational select of the data-memory port between the pipeline and the
// debug dump reader. The pipeline always wins; the debug side only reads.
//   i_rst       forces both memory strobes low
//   i_pipe      MEM-stage request
//   i_dbg_issue debug read wanted this cycle (already gated by the caller)
//   i_dbg_addr  word index for the debug read, zero-extended
//   o_mem       request presented to the memory
module dmem_port_mux
  import mips_pkg::*;
(
  input  logic        i_rst,
  input  mem_req_t    i_pipe,
  input  logic        i_dbg_issue,
  input  logic [31:0] i_dbg_addr,
  output mem_req_t    o_mem
);

  logic pipe_req;
  assign pipe_req = i_pipe.memread | i_pipe.memwrite;

  always_comb begin
    // Idle port follows the pipeline fields; strobes are already 0 then.
    o_mem = i_pipe;
    if (!pipe_req && i_dbg_issue) begin
      o_mem.addr     = i_dbg_addr;
      o_mem.memread  = 1'b1;
      o_mem.memwrite = 1'b0;
      o_mem.long_sz  = LONG_WORD;
      o_mem.sign     = 1'b0;
    end
    if (i_rst) begin
      o_mem.memread  = 1'b0;
      o_mem.memwrite = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage, the debug unit and data memory.
// MEM-stage accesses pass straight through. A debug start pulse launches a
// word-by-word dump of the memory (valid/ready toward the debug unit) that
// only advances while the pipeline is halted and not using the port.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_p_*                        MEM-stage request; o_p_rdata read data back
//   i_dbg_start/halted/ready     debug control inputs
//   o_dbg_data/valid/idx         dumped word, handshake valid, its index
//   o_dbg_busy, o_dbg_done       dump in progress, one-cycle completion pulse
//   o_mem_*, i_mem_rdata         memory port (registered read, 1-cycle)
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_p_addr,
  input  logic [DATA_W-1:0] i_p_wdata,
  input  logic              i_p_memwrite,
  input  logic              i_p_memread,
  input  logic [1:0]        i_p_long,
  input  logic              i_p_memsign,
  output logic [DATA_W-1:0] o_p_rdata,
  input  logic              i_dbg_start,
  input  logic              i_dbg_halted,
  input  logic              i_dbg_ready,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic              o_dbg_valid,
  output logic [IDX_W-1:0]  o_dbg_idx,
  output logic              o_dbg_busy,
  output logic              o_dbg_done,
  output logic [31:0]       o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_memwrite,
  output logic              o_mem_memread,
  output logic [1:0]        o_mem_long,
  output logic              o_mem_sign,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dbg_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_out_q;
  logic              pipe_req;
  logic              dbg_issue;
  logic [31:0]       dbg_addr;
  mem_req_t          pipe_r;
  mem_req_t          mem_r;

  assign pipe_req  = i_p_memread | i_p_memwrite;
  // The debug read only goes out when the pipeline is halted and idle.
  assign dbg_issue = (state_q == ST_ISSUE) && i_dbg_halted && !pipe_req;
  assign dbg_addr  = {{(32-IDX_W){1'b0}}, idx_q};

  assign pipe_r = '{addr: i_p_addr, wdata: i_p_wdata, memwrite: i_p_memwrite,
                    memread: i_p_memread, long_sz: i_p_long, sign: i_p_memsign};

  dmem_port_mux u_mux (
    .i_rst      (i_rst),
    .i_pipe     (pipe_r),
    .i_dbg_issue(dbg_issue),
    .i_dbg_addr (dbg_addr),
    .o_mem      (mem_r)
  );

  assign o_mem_addr     = mem_r.addr;
  assign o_mem_wdata    = mem_r.wdata;
  assign o_mem_memwrite = mem_r.memwrite;
  assign o_mem_memread  = mem_r.memread;
  assign o_mem_long     = mem_r.long_sz;
  assign o_mem_sign     = mem_r.sign;
  assign o_p_rdata      = i_mem_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_dbg_start) state_d = ST_ISSUE;
      ST_ISSUE:   if (dbg_issue) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SEND;
      // SEND ignores halt so a word already read always gets delivered.
      ST_SEND:    if (i_dbg_ready) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      idx_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && i_dbg_start) idx_q <= '0;
      // idx stops at the last word; it is cleared again by the next start.
      if (state_q == ST_SEND && i_dbg_ready && idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
      // Memory output only changes at the end of this cycle, so a pipeline
      // access during CAPTURE cannot disturb the word being latched.
      if (state_q == ST_CAPTURE) begin
        data_q    <= i_mem_rdata;
        idx_out_q <= idx_q;
      end
    end
  end

  assign o_dbg_data  = data_q;
  assign o_dbg_idx   = idx_out_q;
  assign o_dbg_valid = (state_q == ST_SEND);
  assign o_dbg_busy  = (state_q == ST_ISSUE) || (state_q == ST_CAPTURE) || (state_q == ST_SEND);
  assign o_dbg_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import mips_pkg::*;
  localparam int DEPTH = DMEM_DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        p_memwrite, p_memread, p_memsign;
  logic [1:0]  p_long;
  logic        dbg_start, dbg_halted, dbg_ready;
  logic [31:0] dbg_data;
  logic        dbg_valid, dbg_busy, dbg_done;
  logic [4:0]  dbg_idx;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_memwrite, mem_memread, mem_sign;
  logic [1:0]  mem_long;

  dmem_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_p_addr(p_addr), .i_p_wdata(p_wdata), .i_p_memwrite(p_memwrite),
    .i_p_memread(p_memread), .i_p_long(p_long), .i_p_memsign(p_memsign),
    .o_p_rdata(p_rdata),
    .i_dbg_start(dbg_start), .i_dbg_halted(dbg_halted), .i_dbg_ready(dbg_ready),
    .o_dbg_data(dbg_data), .o_dbg_valid(dbg_valid), .o_dbg_idx(dbg_idx),
    .o_dbg_busy(dbg_busy), .o_dbg_done(dbg_done),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_memwrite(mem_memwrite),
    .o_mem_memread(mem_memread), .o_mem_long(mem_long), .o_mem_sign(mem_sign),
    .i_mem_rdata(mem_rdata)
  );

  int vec = 0, miss = 0;

  // Data memory with a registered read port.
  logic [31:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (mem_memwrite) mem_arr[mem_addr[4:0]] <= mem_wdata;
    if (mem_memread)  mem_rdata <= mem_arr[mem_addr[4:0]];
  end

  // Expected memory contents, maintained from the writes the bench performs.
  logic [31:0] shadow [DEPTH];

  // Accepted debug beats and done pulses.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [4:0]  bq_idx [$];
  logic [31:0] bq_data [$];
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  always @(negedge clk) begin
    if (dbg_valid && dbg_ready) begin
      bq_idx.push_back(dbg_idx);
      bq_data.push_back(dbg_data);
    end
    if (dbg_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pwrite(input logic [4:0] a, input logic [31:0] d);
    p_addr = {27'b0, a}; p_wdata = d; p_memwrite = 1'b1; p_long = LONG_WORD;
    tick();
    p_memwrite = 1'b0;
    shadow[a] = d;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (dbg_done) begin ok = 1'b1; break; end
    end
  endtask

  // Returns at the start of the SEND cycle showing index 'target'.
  task automatic wait_beat(input int target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (dbg_valid && dbg_idx == 5'(target)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; p_addr = 32'd3; p_wdata = 32'h1234_5678; p_memwrite = 1'b1; p_memread = 1'b1;
    p_long = LONG_WORD; p_memsign = 1'b0; dbg_start = 1'b0; dbg_halted = 1'b0; dbg_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    vec++; if ({mem_memwrite, mem_memread} !== 2'b00) begin
      miss++; $display("FAIL reset_strobes: got %b want 00", {mem_memwrite, mem_memread}); end
    vec++; if ({dbg_valid, dbg_busy, dbg_done} !== 3'b000) begin
      miss++; $display("FAIL reset_status: got %b want 000", {dbg_valid, dbg_busy, dbg_done}); end
    vec++; if (dbg_data !== 32'd0 || dbg_idx !== 5'd0) begin
      miss++; $display("FAIL reset_data: got %h/%0d want 0/0", dbg_data, dbg_idx); end
    p_memwrite = 1'b0; p_memread = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    p_addr = 32'd3; p_wdata = 32'hDEADBEEF; p_memwrite = 1'b1; p_long = LONG_WORD; p_memsign = 1'b1;
    @(negedge clk);
    vec++; if ({mem_addr, mem_wdata, mem_memwrite, mem_memread, mem_long, mem_sign} !==
               {32'd3, 32'hDEADBEEF, 1'b1, 1'b0, 2'b11, 1'b1}) begin
      miss++; $display("FAIL pass_write: got %h %h %b%b want 3 deadbeef 10", mem_addr, mem_wdata, mem_memwrite, mem_memread); end
    tick();
    shadow[3] = 32'hDEADBEEF;
    p_memwrite = 1'b0; p_memread = 1'b1; p_memsign = 1'b0;
    @(negedge clk);
    vec++; if (mem_memread !== 1'b1 || mem_addr !== 32'd3) begin
      miss++; $display("FAIL pass_read: got rd=%b addr=%h want 1/3", mem_memread, mem_addr); end
    tick();
    p_memread = 1'b0;
    @(negedge clk);
    vec++; if (p_rdata !== 32'hDEADBEEF) begin
      miss++; $display("FAIL pass_rdata: got %h want deadbeef", p_rdata); end
    vec++; if ({dbg_busy, dbg_valid, mem_memread, mem_memwrite} !== 4'b0000) begin
      miss++; $display("FAIL pass_idle: got %b want 0000", {dbg_busy, dbg_valid, mem_memread, mem_memwrite}); end
  endtask

  task automatic test_full_dump();
    bit ok; int qb, dc; int unsigned c0;
    for (int i = 0; i < DEPTH; i++) pwrite(5'(i), 32'h1000_0000 + 32'(i));
    dbg_halted = 1'b1; dbg_ready = 1'b1;
    qb = bq_idx.size(); dc = done_cnt;
    dbg_start = 1'b1; tick(); dbg_start = 1'b0; c0 = cyc;
    wait_done(ok);
    tick();
    vec++; if (!ok) begin miss++; $display("FAIL dump_done_seen: got timeout want done"); end
    vec++; if (done_cyc - c0 + 1 !== 3*DEPTH+1) begin
      miss++; $display("FAIL dump_latency: got %0d want %0d", done_cyc - c0 + 1, 3*DEPTH+1); end
    vec++; if (done_cnt - dc !== 1) begin miss++; $display("FAIL dump_done_cnt: got %0d want 1", done_cnt - dc); end
    @(negedge clk);
    vec++; if ({dbg_busy, dbg_done, dbg_valid} !== 3'b000) begin
      miss++; $display("FAIL dump_after: got %b want 000", {dbg_busy, dbg_done, dbg_valid}); end
    vec++; if (bq_idx.size() - qb !== DEPTH) begin
      miss++; $display("FAIL dump_beats: got %0d want %0d", bq_idx.size() - qb, DEPTH); end
    for (int i = 0; i < DEPTH && qb + i < bq_idx.size(); i++) begin
      vec++; if (bq_idx[qb+i] !== 5'(i) || bq_data[qb+i] !== shadow[i]) begin
        miss++; $display("FAIL dump_beat%0d: got %0d/%h want %0d/%h", i, bq_idx[qb+i], bq_data[qb+i], i, shadow[i]); end
    end
  endtask

  task automatic test_backpressure();
    int qb, hold; bit first;
    qb = bq_idx.size(); hold = 0; first = 1'b0; dbg_ready = 1'b1;
    dbg_start = 1'b1; tick(); dbg_start = 1'b0;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (dbg_done) break;
      if (dbg_valid && dbg_idx == 5'd7 && hold == 0) first = 1'b1;
      if (first && hold < 5) begin
        vec++; if (dbg_valid !== 1'b1 || dbg_idx !== 5'd7 || dbg_data !== 32'h1000_0007) begin
          miss++; $display("FAIL bp_hold%0d: got v=%b %0d/%h want 1 7/10000007", hold, dbg_valid, dbg_idx, dbg_data); end
        dbg_ready = 1'b0; hold++;
      end else dbg_ready = 1'b1;
    end
    dbg_ready = 1'b1;
    tick();
    vec++; if (hold !== 5) begin miss++; $display("FAIL bp_stall_cycles: got %0d want 5", hold); end
    vec++; if (bq_idx.size() - qb !== DEPTH) begin
      miss++; $display("FAIL bp_beats: got %0d want %0d", bq_idx.size() - qb, DEPTH); end
    for (int i = 0; i < DEPTH && qb + i < bq_idx.size(); i++) begin
      vec++; if (bq_idx[qb+i] !== 5'(i) || bq_data[qb+i] !== shadow[i]) begin
        miss++; $display("FAIL bp_beat%0d: got %0d/%h want %0d/%h", i, bq_idx[qb+i], bq_data[qb+i], i, shadow[i]); end
    end
  endtask

  task automatic test_halt_drop();
    bit ok; int qb;
    qb = bq_idx.size(); dbg_halted = 1'b1; dbg_ready = 1'b1;
    dbg_start = 1'b1; tick(); dbg_start = 1'b0;
    wait_beat(9, ok);
    vec++; if (!ok) begin miss++; $display("FAIL halt_reach9: got timeout want beat 9"); end
    dbg_halted = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      p_addr = 32'd20; p_wdata = 32'hCAFEF00D; p_long = LONG_WORD; p_memwrite = (k == 1);
      @(negedge clk);
      vec++; if ({dbg_valid, dbg_busy, mem_memread} !== 3'b010) begin
        miss++; $display("FAIL halt_pause%0d: got %b want 010", k, {dbg_valid, dbg_busy, mem_memread}); end
      if (k == 1) begin
        vec++; if ({mem_addr, mem_wdata, mem_memwrite} !== {32'd20, 32'hCAFEF00D, 1'b1}) begin
          miss++; $display("FAIL halt_pwrite: got %h %h %b want 14 cafef00d 1", mem_addr, mem_wdata, mem_memwrite); end
      end
    end
    p_memwrite = 1'b0; shadow[20] = 32'hCAFEF00D; dbg_halted = 1'b1;
    wait_done(ok);
    tick();
    vec++; if (!ok) begin miss++; $display("FAIL halt_done_seen: got timeout want done"); end
    vec++; if (bq_idx.size() - qb !== DEPTH) begin
      miss++; $display("FAIL halt_beats: got %0d want %0d", bq_idx.size() - qb, DEPTH); end
    for (int i = 0; i < DEPTH && qb + i < bq_idx.size(); i++) begin
      vec++; if (bq_idx[qb+i] !== 5'(i) || bq_data[qb+i] !== shadow[i]) begin
        miss++; $display("FAIL halt_beat%0d: got %0d/%h want %0d/%h", i, bq_idx[qb+i], bq_data[qb+i], i, shadow[i]); end
    end
    if (qb + 20 < bq_idx.size()) begin
      vec++; if (bq_data[qb+20] !== 32'hCAFEF00D) begin
        miss++; $display("FAIL halt_word20: got %h want cafef00d", bq_data[qb+20]); end
    end
  endtask

  task automatic test_collision();
    bit ok; int qb; int unsigned c0;
    qb = bq_idx.size();
    dbg_start = 1'b1; tick(); dbg_start = 1'b0; c0 = cyc;
    wait_beat(4, ok);
    vec++; if (!ok) begin miss++; $display("FAIL col_reach4: got timeout want beat 4"); end
    p_addr = 32'd25; p_memread = 1'b1; p_long = LONG_HALF; p_memsign = 1'b1;
    tick();
    @(negedge clk);
    vec++; if ({mem_addr, mem_memread, mem_long, mem_sign, dbg_valid} !== {32'd25, 1'b1, 2'b01, 1'b1, 1'b0}) begin
      miss++; $display("FAIL col_pipe_wins: got %h %b %b %b want 19 1 01 1", mem_addr, mem_memread, mem_long, mem_sign); end
    tick();
    p_memread = 1'b0;
    @(negedge clk);
    vec++; if ({mem_addr, mem_memread, mem_memwrite, mem_long, mem_sign} !== {32'd5, 1'b1, 1'b0, 2'b11, 1'b0}) begin
      miss++; $display("FAIL col_dbg_issue: got %h %b%b %b %b want 5 10 11 0", mem_addr, mem_memread, mem_memwrite, mem_long, mem_sign); end
    tick();
    p_memread = 1'b1;
    @(negedge clk);
    vec++; if (mem_addr !== 32'd25) begin miss++; $display("FAIL col_capture_addr: got %h want 19", mem_addr); end
    tick();
    p_memread = 1'b0; p_memsign = 1'b0; p_long = LONG_WORD;
    wait_done(ok);
    tick();
    vec++; if (!ok || done_cyc - c0 + 1 !== 3*DEPTH+2) begin
      miss++; $display("FAIL col_latency: got %0d want %0d", done_cyc - c0 + 1, 3*DEPTH+2); end
    vec++; if (bq_idx.size() - qb !== DEPTH) begin
      miss++; $display("FAIL col_beats: got %0d want %0d", bq_idx.size() - qb, DEPTH); end
    for (int i = 0; i < DEPTH && qb + i < bq_idx.size(); i++) begin
      vec++; if (bq_idx[qb+i] !== 5'(i) || bq_data[qb+i] !== shadow[i]) begin
        miss++; $display("FAIL col_beat%0d: got %0d/%h want %0d/%h", i, bq_idx[qb+i], bq_data[qb+i], i, shadow[i]); end
    end
  endtask

  task automatic test_control();
    bit ok; int qb, dc; int unsigned c0;
    qb = bq_idx.size(); dc = done_cnt;
    dbg_start = 1'b1; tick(); dbg_start = 1'b0; c0 = cyc;
    wait_beat(3, ok);
    dbg_start = 1'b1; tick(); dbg_start = 1'b0;
    wait_done(ok);
    tick();
    vec++; if (!ok || done_cyc - c0 + 1 !== 3*DEPTH+1 || done_cnt - dc !== 1) begin
      miss++; $display("FAIL ctl_restart_ignored: got lat %0d dones %0d want %0d 1", done_cyc - c0 + 1, done_cnt - dc, 3*DEPTH+1); end
    vec++; if (bq_idx.size() - qb !== DEPTH) begin
      miss++; $display("FAIL ctl_beats: got %0d want %0d", bq_idx.size() - qb, DEPTH); end
    for (int i = 0; i < DEPTH && qb + i < bq_idx.size(); i++) begin
      vec++; if (bq_idx[qb+i] !== 5'(i)) begin
        miss++; $display("FAIL ctl_beat%0d: got %0d want %0d", i, bq_idx[qb+i], i); end
    end
  endtask

  task automatic test_reset_mid_dump();
    bit ok; int dc;
    dbg_start = 1'b1; tick(); dbg_start = 1'b0;
    wait_beat(15, ok);
    vec++; if (!ok) begin miss++; $display("FAIL rstmid_reach15: got timeout want beat 15"); end
    dc = done_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    vec++; if ({dbg_valid, dbg_busy, dbg_done} !== 3'b000 || dbg_idx !== 5'd0) begin
      miss++; $display("FAIL rstmid_status: got %b idx %0d want 000 idx 0", {dbg_valid, dbg_busy, dbg_done}, dbg_idx); end
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    vec++; if (done_cnt !== dc || dbg_busy !== 1'b0) begin
      miss++; $display("FAIL rstmid_idle: got dones %0d busy %b want %0d 0", done_cnt, dbg_busy, dc); end
  endtask

  task automatic test_random();
    bit ok; int qb;
    for (int r = 0; r < 3; r++) begin
      qb = bq_idx.size(); ok = 1'b0;
      dbg_start = 1'b1; tick(); dbg_start = 1'b0;
      for (int n = 0; n < 4000; n++) begin
        tick();
        dbg_ready  = 1'($urandom_range(0, 1));
        dbg_halted = ($urandom_range(0, 3) != 0);
        p_memread  = ($urandom_range(0, 3) == 0);
        p_addr     = 32'($urandom_range(0, DEPTH-1));
        p_long     = ($urandom_range(0, 1) != 0) ? LONG_WORD : LONG_BYTE;
        p_memsign  = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (p_memread) begin
          vec++; if ({mem_addr, mem_memread, mem_memwrite, mem_long, mem_sign} !== {p_addr, 1'b1, 1'b0, p_long, p_memsign}) begin
            miss++; $display("FAIL rnd_grant: got %h %b%b %b %b want %h 10 %b %b", mem_addr, mem_memread, mem_memwrite, mem_long, mem_sign, p_addr, p_long, p_memsign); end
        end else begin
          vec++; if (mem_memwrite !== 1'b0 || (mem_memread && (mem_addr >= 32'(DEPTH) || mem_long !== LONG_WORD || !dbg_halted))) begin
            miss++; $display("FAIL rnd_dbgport: got wr=%b rd=%b addr %h long %b want debug word read only", mem_memwrite, mem_memread, mem_addr, mem_long); end
        end
        if (dbg_done) begin ok = 1'b1; break; end
      end
      p_memread = 1'b0; dbg_ready = 1'b1; dbg_halted = 1'b1;
      tick();
      vec++; if (!ok || bq_idx.size() - qb !== DEPTH) begin
        miss++; $display("FAIL rnd%0d_beats: got %0d done %b want %0d 1", r, bq_idx.size() - qb, ok, DEPTH); end
      for (int i = 0; i < DEPTH && qb + i < bq_idx.size(); i++) begin
        vec++; if (bq_idx[qb+i] !== 5'(i) || bq_data[qb+i] !== shadow[i]) begin
          miss++; $display("FAIL rnd%0d_beat%0d: got %0d/%h want %0d/%h", r, i, bq_idx[qb+i], bq_data[qb+i], i, shadow[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_full_dump();
    test_backpressure();
    test_halt_drop();
    test_collision();
    test_control();
    test_reset_mid_dump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
